puck_mover: RTL and testbench

Per-frame motion controller for the air-hockey puck. It is the consumer side of the collision handshake. On each frame tick it does four things in order:
- erases the 4x4 puck box from the VGA framebuffer;
- pulses the collision checker with the current position;
- applies any reported direction flips and steps the puck one pixel on each axis;
- redraws the box.

It sits between the frame-tick generator, the `collision` block and the VGA adapter's plot port.

---
 rtl/puck_pkg.sv | 21 ++
 rtl/box_scan.sv | 27 ++
 rtl/puck_mover.sv | 132 +++++++++++++
 tb/tb_puck_mover.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puck_pkg.sv
// Shared screen geometry, FSM state encoding and colour type for the puck mover.
package puck_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int BOX      = 4;
  localparam int X_MAX    = SCREEN_W - BOX;
  localparam int Y_MAX    = SCREEN_H - BOX;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_CHECK,
    ST_SETTLE,
    ST_MOVE,
    ST_DRAW
  } state_t;

  typedef logic [2:0] colour_t;

endpackage

// File: rtl/box_scan.sv
// 4-bit pixel counter that walks the 4x4 puck box row-major; shared by erase and draw.
module box_scan (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  output logic       done,
  output logic [1:0] off_x,
  output logic [1:0] off_y
);

  logic [3:0] cnt;

  // Clear on start, otherwise step once per plotted pixel.
  always_ff @(posedge clock) begin
    if (reset || start) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign done  = (cnt == 4'hF);
  assign off_x = cnt[1:0];
  assign off_y = cnt[3:2];

endmodule

// File: rtl/puck_mover.sv
// Per-frame puck controller: erase box, request collision check, bounce/step, redraw box.
module puck_mover
  import puck_pkg::*;
#(
  parameter int      START_X     = 158,
  parameter int      START_Y     = 118,
  parameter bit      START_DIR_X = 1'b0,
  parameter bit      START_DIR_Y = 1'b0,
  parameter colour_t PUCK_COLOUR = 3'b111,
  parameter colour_t BG_COLOUR   = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       move_tick,
  input  logic       flip_horizontal,
  input  logic       flip_vertical,
  output logic       collide_en,
  output logic [8:0] x_pos,
  output logic [7:0] y_pos,
  output logic       plot,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       busy
);

  state_t     state;
  logic       dir_x;
  logic       dir_y;
  logic       prev_h;
  logic       prev_v;
  logic       dir_x_n;
  logic       dir_y_n;
  logic [8:0] x_next;
  logic [7:0] y_next;
  logic       scan_start;
  logic       scan_adv;
  logic       scan_done;
  logic [1:0] off_x;
  logic [1:0] off_y;

  // One-pixel step that refuses to leave the playfield, even with a stale direction.
  function automatic logic [8:0] step_x(input logic [8:0] pos, input logic dir);
    if (!dir && (pos < 9'(X_MAX))) begin
      return pos + 9'd1;
    end else if (dir && (pos != 9'd0)) begin
      return pos - 9'd1;
    end else begin
      return pos;
    end
  endfunction

  function automatic logic [7:0] step_y(input logic [7:0] pos, input logic dir);
    if (!dir && (pos < 8'(Y_MAX))) begin
      return pos + 8'd1;
    end else if (dir && (pos != 8'd0)) begin
      return pos - 8'd1;
    end else begin
      return pos;
    end
  endfunction

  // Collision flags are toggle-type: any change since the last frame reverses that axis.
  assign dir_x_n = dir_x ^ (flip_horizontal != prev_h);
  assign dir_y_n = dir_y ^ (flip_vertical != prev_v);
  assign x_next  = step_x(x_pos, dir_x_n);
  assign y_next  = step_y(y_pos, dir_y_n);

  assign scan_start = ((state == ST_IDLE) && move_tick) || (state == ST_MOVE);
  assign scan_adv   = (state == ST_ERASE) || (state == ST_DRAW);

  box_scan u_box_scan (
    .clock   (clock),
    .reset   (reset),
    .start   (scan_start),
    .advance (scan_adv),
    .done    (scan_done),
    .off_x   (off_x),
    .off_y   (off_y)
  );

  // Frame sequencer; position and direction only change on the MOVE edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      x_pos  <= 9'(START_X);
      y_pos  <= 8'(START_Y);
      dir_x  <= START_DIR_X;
      dir_y  <= START_DIR_Y;
      prev_h <= flip_horizontal;
      prev_v <= flip_vertical;
    end else begin
      case (state)
        ST_IDLE: begin
          if (move_tick) state <= ST_ERASE;
        end
        ST_ERASE: begin
          if (scan_done) state <= ST_CHECK;
        end
        ST_CHECK: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          state <= ST_MOVE;
        end
        ST_MOVE: begin
          state  <= ST_DRAW;
          dir_x  <= dir_x_n;
          dir_y  <= dir_y_n;
          prev_h <= flip_horizontal;
          prev_v <= flip_vertical;
          x_pos  <= x_next;
          y_pos  <= y_next;
        end
        ST_DRAW: begin
          if (scan_done) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state != ST_IDLE);
  assign plot       = scan_adv;
  assign collide_en = (state == ST_CHECK);
  assign vga_x      = plot ? (x_pos + {7'd0, off_x}) : 9'd0;
  assign vga_y      = plot ? (y_pos + {6'd0, off_y}) : 8'd0;
  assign vga_colour = (state == ST_DRAW) ? PUCK_COLOUR : BG_COLOUR;

endmodule

// File: tb/tb_puck_mover.sv
// Bench for puck_mover: four parameterisations driven from one tick/reset, with a
// frame-timeline reference model, a directed vector table and corner-case sequences.
module tb_puck_mover;

  localparam int N = 4;
  // 0: centre/random flips, 1: left wall, 2: corner, 3: parked at origin with stale dirs
  localparam int SX  [N] = '{158, 1, 316, 0};
  localparam int SY  [N] = '{118, 118, 236, 0};
  localparam bit SDX [N] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit SDY [N] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic clock = 1'b0;
  logic reset;
  logic move_tick;
  logic rnd_h;
  logic rnd_v;
  logic [1:0] col_h = '0;
  logic [1:0] col_v = '0;
  logic [N-1:0] fh;
  logic [N-1:0] fv;

  logic [N-1:0] cen;
  logic [N-1:0] plt;
  logic [N-1:0] bsy;
  logic [8:0] xp [N];
  logic [7:0] yp [N];
  logic [8:0] vx [N];
  logic [7:0] vy [N];
  logic [2:0] vc [N];

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  always #5 clock = ~clock;

  assign fh = {1'b0, col_h, rnd_h};
  assign fv = {1'b0, col_v, rnd_v};

  for (genvar g = 0; g < N; g++) begin : g_dut
    puck_mover #(
      .START_X     (SX[g]),
      .START_Y     (SY[g]),
      .START_DIR_X (SDX[g]),
      .START_DIR_Y (SDY[g]),
      .PUCK_COLOUR (3'b111),
      .BG_COLOUR   (3'b000)
    ) u_dut (
      .clock           (clock),
      .reset           (reset),
      .move_tick       (move_tick),
      .flip_horizontal (fh[g]),
      .flip_vertical   (fv[g]),
      .collide_en      (cen[g]),
      .x_pos           (xp[g]),
      .y_pos           (yp[g]),
      .plot            (plt[g]),
      .vga_x           (vx[g]),
      .vga_y           (vy[g]),
      .vga_colour      (vc[g]),
      .busy            (bsy[g])
    );
  end

  // Stand-in for the collision block on instances 1 and 2: toggle a flag when the
  // box touches a wall at the time collide_en is sampled.
  always @(posedge clock) begin
    if (cen[1]) begin
      if (xp[1] == 9'd0 || xp[1] == 9'd316) col_h[0] <= ~col_h[0];
      if (yp[1] == 8'd0 || yp[1] == 8'd236) col_v[0] <= ~col_v[0];
    end
    if (cen[2]) begin
      if (xp[2] == 9'd0 || xp[2] == 9'd316) col_h[1] <= ~col_h[1];
      if (yp[2] == 8'd0 || yp[2] == 8'd236) col_v[1] <= ~col_v[1];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic int step(input int p, input bit d, input int mx);
    if (!d && p < mx) return p + 1;
    if (d && p > 0) return p - 1;
    return p;
  endfunction

  // Reference model: a frame is a 35-cycle timeline after an accepted tick
  // (1..16 erase, 17 check, 19 move edge, 20..35 draw).
  initial begin : model
    int mx [N];
    int my [N];
    bit mdx [N];
    bit mdy [N];
    bit mph [N];
    bit mpv [N];
    int k;
    bit e_plot;
    int p;
    int ex;
    int ey;
    int ec;
    longint e;
    longint a;
    k = 0;
    forever begin
      @(negedge clock);
      if (model_on) begin
        for (int i = 0; i < N; i++) begin
          e_plot = (k >= 1 && k <= 16) || (k >= 20 && k <= 35);
          p  = (k <= 16) ? k - 1 : k - 20;
          ex = e_plot ? mx[i] + (p % 4) : 0;
          ey = e_plot ? my[i] + (p / 4) : 0;
          ec = (k >= 20) ? 7 : 0;
          e = {longint'(e_plot), longint'(k == 17), longint'(k != 0)};
          e = (e << 3) | longint'(ec);
          e = (e << 9) | longint'(ex);
          e = (e << 8) | longint'(ey);
          e = (e << 9) | longint'(mx[i]);
          e = (e << 8) | longint'(my[i]);
          a = {longint'(plt[i]), longint'(cen[i]), longint'(bsy[i])};
          a = (a << 3) | longint'(vc[i]);
          a = (a << 9) | longint'(vx[i]);
          a = (a << 8) | longint'(vy[i]);
          a = (a << 9) | longint'(xp[i]);
          a = (a << 8) | longint'(yp[i]);
          chk($sformatf("model_inst%0d_k%0d", i, k), a, e);
        end
      end
      if (reset) begin
        k = 0;
        for (int i = 0; i < N; i++) begin
          mx[i] = SX[i];  my[i] = SY[i];
          mdx[i] = SDX[i]; mdy[i] = SDY[i];
          mph[i] = fh[i]; mpv[i] = fv[i];
        end
      end else if (k == 0) begin
        if (move_tick) k = 1;
      end else begin
        if (k == 19) begin
          for (int i = 0; i < N; i++) begin
            if (fh[i] != mph[i]) mdx[i] = ~mdx[i];
            if (fv[i] != mpv[i]) mdy[i] = ~mdy[i];
            mph[i] = fh[i];
            mpv[i] = fv[i];
            mx[i] = step(mx[i], mdx[i], 316);
            my[i] = step(my[i], mdy[i], 236);
          end
        end
        k = (k == 35) ? 0 : k + 1;
      end
    end
  end

  typedef struct {
    int k;
    int plot;
    int vx;
    int vy;
    int col;
    int cen;
    int busy;
    int xp;
    int yp;
  } vec_t;

  vec_t tbl [12];

  initial begin : main
    int ti;
    int bc;
    int pc;

    // Expected cycle-by-cycle view of the centre frame on instance 0.
    tbl[0]  = '{1,  1, 158, 118, 0, 0, 1, 158, 118};
    tbl[1]  = '{4,  1, 161, 118, 0, 0, 1, 158, 118};
    tbl[2]  = '{5,  1, 158, 119, 0, 0, 1, 158, 118};
    tbl[3]  = '{16, 1, 161, 121, 0, 0, 1, 158, 118};
    tbl[4]  = '{17, 0, 0,   0,   0, 1, 1, 158, 118};
    tbl[5]  = '{18, 0, 0,   0,   0, 0, 1, 158, 118};
    tbl[6]  = '{19, 0, 0,   0,   0, 0, 1, 158, 118};
    tbl[7]  = '{20, 1, 159, 119, 7, 0, 1, 159, 119};
    tbl[8]  = '{23, 1, 162, 119, 7, 0, 1, 159, 119};
    tbl[9]  = '{24, 1, 159, 120, 7, 0, 1, 159, 119};
    tbl[10] = '{35, 1, 162, 122, 7, 0, 1, 159, 119};
    tbl[11] = '{36, 0, 0,   0,   0, 0, 0, 159, 119};

    reset = 1'b1;
    move_tick = 1'b0;
    rnd_h = 1'b0;
    rnd_v = 1'b0;

    // Reset state
    cyc();
    cyc();
    chk("rst_x_pos", xp[0], 158);
    chk("rst_y_pos", yp[0], 118);
    chk("rst_plot", plt[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_collide_en", cen[0], 0);
    chk("rst_vga_x", vx[0], 0);
    chk("rst_vga_colour", vc[0], 0);
    reset = 1'b0;
    model_on = 1'b1;
    cyc();

    // Centre frame, table driven
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    ti = 0; bc = 0; pc = 0;
    for (int k = 1; k <= 36; k++) begin
      bc += int'(bsy[0]);
      pc += int'(plt[0]);
      if (ti < 12 && tbl[ti].k == k) begin
        chk($sformatf("tbl_k%0d_plot", k), plt[0], tbl[ti].plot);
        chk($sformatf("tbl_k%0d_vga_x", k), vx[0], tbl[ti].vx);
        chk($sformatf("tbl_k%0d_vga_y", k), vy[0], tbl[ti].vy);
        chk($sformatf("tbl_k%0d_colour", k), vc[0], tbl[ti].col);
        chk($sformatf("tbl_k%0d_collide_en", k), cen[0], tbl[ti].cen);
        chk($sformatf("tbl_k%0d_busy", k), bsy[0], tbl[ti].busy);
        chk($sformatf("tbl_k%0d_x_pos", k), xp[0], tbl[ti].xp);
        chk($sformatf("tbl_k%0d_y_pos", k), yp[0], tbl[ti].yp);
        ti++;
      end
      cyc();
    end
    chk("centre_busy_cycles", bc, 35);
    chk("centre_plot_cycles", pc, 32);

    // Frame 1 on wall/corner/origin instances
    chk("wall_f1_x", xp[1], 0);
    chk("wall_f1_flip_h", col_h[0], 0);
    chk("corner_f1_x", xp[2], 315);
    chk("corner_f1_y", yp[2], 235);
    chk("corner_f1_flip_h", col_h[1], 1);
    chk("corner_f1_flip_v", col_v[1], 1);
    chk("origin_f1_x", xp[3], 0);
    chk("origin_f1_y", yp[3], 0);

    // Frame 2: wall bounce
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    repeat (36) cyc();
    chk("wall_f2_flip_h", col_h[0], 1);
    chk("wall_f2_x", xp[1], 1);
    chk("corner_f2_x", xp[2], 314);
    chk("corner_f2_y", yp[2], 234);
    chk("origin_f2_y", yp[3], 0);

    // Dropped tick at N+10
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    bc = 0; pc = 0;
    for (int c = 1; c <= 40; c++) begin
      bc += int'(bsy[0]);
      pc += int'(plt[0]);
      if (c == 36) chk("drop_idle_at_36", bsy[0], 0);
      if (c == 9) move_tick = 1'b1;
      cyc();
      move_tick = 1'b0;
    end
    chk("drop_busy_cycles", bc, 35);
    chk("drop_plot_cycles", pc, 32);

    // Reset during the fifth draw pixel
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    repeat (23) cyc();
    chk("middraw_plot", plt[0], 1);
    chk("middraw_colour", vc[0], 7);
    reset = 1'b1;
    cyc();
    chk("middraw_rst_plot", plt[0], 0);
    chk("middraw_rst_busy", bsy[0], 0);
    chk("middraw_rst_x", xp[0], 158);
    chk("middraw_rst_y", yp[0], 118);
    reset = 1'b0;
    cyc();

    // Randomised ticks and flips, checked by the model
    for (int c = 0; c < 8000; c++) begin
      move_tick = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) rnd_h = ~rnd_h;
      if ($urandom_range(0, 7) == 0) rnd_v = ~rnd_v;
      cyc();
    end
    move_tick = 1'b0;
    repeat (40) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
